// File: rtl/states_pkg.sv
// Shared state encodings for the core pipeline, the memory controller and the LSU.
package states_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE          = 2'd0,
    CTRL_READ_WAITING  = 2'd1,
    CTRL_WRITE_WAITING = 2'd2,
    CTRL_RELAYING      = 2'd3
  } controller_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: issues one read or write on the controller's
// consumer channel per instruction, with a sticky timeout flag.
module lsu #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);
  import states_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t           state_q, state_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 start;
  logic                 ack;
  logic                 timeout;
  logic [CNT_W-1:0]     cnt_inc;

  generate
    if (DATA_BITS > ADDR_BITS) begin : g_rs_hi
      logic unused_rs_hi;
      assign unused_rs_hi = ^rs[DATA_BITS-1:ADDR_BITS];
    end
  endgenerate

  // A still-high ready from the previous transaction blocks a new issue.
  assign start = enable && (core_state_t'(core_state) == CORE_REQUEST)
              && (decoded_mem_read_enable || decoded_mem_write_enable)
              && !mem_read_ready && !mem_write_ready;

  assign ack     = (rd_valid_q && mem_read_ready) || (wr_valid_q && mem_write_ready);
  assign cnt_inc = (cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = !ack && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LSU_IDLE;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:       if (start) state_d = LSU_REQUESTING;
      LSU_REQUESTING: state_d = LSU_WAITING;
      LSU_WAITING:    if (ack || timeout) state_d = LSU_DONE;
      LSU_DONE:       if (core_state_t'(core_state) == CORE_UPDATE) state_d = LSU_IDLE;
      default:        state_d = LSU_IDLE;
    endcase
  end

  // Completion wins over timeout when ready lands on the final wait cycle.
  always_comb begin
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (decoded_mem_read_enable) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = rs[ADDR_BITS-1:0];
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = rs[ADDR_BITS-1:0];
            wr_data_d  = rt;
          end
        end
      end
      LSU_WAITING: begin
        cnt_d = cnt_inc;
        if (ack) begin
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          if (rd_valid_q) out_d = mem_read_data;
        end else if (timeout) begin
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          err_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign lsu_state         = state_q;
  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_out           = out_q;
  assign lsu_error         = err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, stale-ack / reset corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_lsu;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    core_state;
  logic          rd_en, wr_en;
  logic [DW-1:0] rs, rt;
  logic          mem_read_valid, mem_write_valid;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic          mem_read_ready, mem_write_ready;
  logic [DW-1:0] mem_read_data, mem_write_data;
  logic [1:0]    lsu_state;
  logic [DW-1:0] lsu_out;
  logic          lsu_error;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_out;
  logic          model_err;

  lsu #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    int            n;
    logic [DW-1:0] rdata;
    logic          exp_is_rd;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    int            exp_done;
    logic [DW-1:0] exp_out;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction; the bench acts as a controller answering n cycles late.
  task automatic run_txn(input logic rd_i, input logic wr_i, input logic [DW-1:0] rs_i,
                         input logic [DW-1:0] rt_i, input int n, input logic [DW-1:0] rdata,
                         input bit drop_en, input logic exp_is_rd, input logic [AW-1:0] exp_addr,
                         input logic [DW-1:0] exp_wdata, input int exp_done,
                         input logic [DW-1:0] exp_out, input logic exp_err);
    int done_cyc;
    enable = 1'b1; core_state = 3'd3; rd_en = rd_i; wr_en = wr_i;
    rs = rs_i; rt = rt_i; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    step();
    chk("req_state", lsu_state, 32'd1);
    chk("req_rd_valid", mem_read_valid, exp_is_rd);
    chk("req_wr_valid", mem_write_valid, !exp_is_rd);
    if (exp_is_rd) chk("req_rd_addr", mem_read_address, exp_addr);
    else begin
      chk("req_wr_addr", mem_write_address, exp_addr);
      chk("req_wr_data", mem_write_data, exp_wdata);
    end
    core_state = 3'd4; rd_en = 1'b0; wr_en = 1'b0;
    rs = DW'($urandom); rt = DW'($urandom);
    if (drop_en) enable = 1'b0;
    done_cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (lsu_state == 2'd3) begin
        done_cyc = k;
        break;
      end
      if (exp_is_rd) begin
        chk("hold_rd_valid", mem_read_valid, 32'd1);
        chk("hold_rd_addr", mem_read_address, exp_addr);
      end else begin
        chk("hold_wr_valid", mem_write_valid, 32'd1);
        chk("hold_wr_addr", mem_write_address, exp_addr);
        chk("hold_wr_data", mem_write_data, exp_wdata);
      end
      if (k == n + 1) begin
        if (exp_is_rd) begin
          mem_read_ready = 1'b1;
          mem_read_data = rdata;
        end else mem_write_ready = 1'b1;
      end
    end
    chk("done_cycle", done_cyc, exp_done);
    chk("done_rd_valid", mem_read_valid, 32'd0);
    chk("done_wr_valid", mem_write_valid, 32'd0);
    chk("done_lsu_out", lsu_out, exp_out);
    chk("done_lsu_error", lsu_error, exp_err);
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = DW'($urandom);
    core_state = 3'd5;
    step();
    chk("done_hold", lsu_state, 32'd3);
    core_state = 3'd6;
    step();
    chk("back_idle", lsu_state, 32'd0);
    core_state = 3'd0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; core_state = 3'd0; rd_en = 1'b0; wr_en = 1'b0;
    rs = '0; rt = '0; mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    @(negedge clk);
    step(); step();
    chk("rst_state", lsu_state, 32'd0);
    chk("rst_rd_valid", mem_read_valid, 32'd0);
    chk("rst_wr_valid", mem_write_valid, 32'd0);
    chk("rst_rd_addr", mem_read_address, 32'd0);
    chk("rst_wr_addr", mem_write_address, 32'd0);
    chk("rst_wr_data", mem_write_data, 32'd0);
    chk("rst_lsu_out", lsu_out, 32'd0);
    chk("rst_lsu_error", lsu_error, 32'd0);
    reset = 1'b0;

    // rd wr rs rt n rdata | is_rd addr wdata done out err   (TIMEOUT_CYCLES = 4)
    vecs[0] = '{1'b1, 1'b0, 16'h0105, 16'h0000, 3, 16'hBEEF, 1'b1, 8'h05, 16'h0000, 5, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0022, 16'h1234, 1, 16'h0000, 1'b0, 8'h22, 16'h1234, 3, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h0010, 16'h9999, 0, 16'h5A5A, 1'b1, 8'h10, 16'h0000, 2, 16'h5A5A, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'hAB77, 16'hCAFE, 2, 16'h0000, 1'b0, 8'h77, 16'hCAFE, 4, 16'h5A5A, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1, 16'h0001, 1'b1, 8'hFF, 16'h0000, 3, 16'h0001, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 9, 16'hDEAD, 1'b1, 8'h42, 16'h0000, 5, 16'h0001, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 16'h0033, 16'h7777, 7, 16'h0000, 1'b0, 8'h33, 16'h7777, 5, 16'h0001, 1'b1};
    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].rs, vecs[i].rt, vecs[i].n, vecs[i].rdata, (i == 4),
              vecs[i].exp_is_rd, vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_done,
              vecs[i].exp_out, vecs[i].exp_err);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_lsu_error", lsu_error, 32'd0);
    chk("rst2_lsu_out", lsu_out, 32'd0);

    // Stale acknowledge: ready still high with a request pending.
    mem_read_ready = 1'b1; enable = 1'b1; core_state = 3'd3; rd_en = 1'b1; rs = 16'h0099;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("stale_state", lsu_state, 32'd0);
      chk("stale_rd_valid", mem_read_valid, 32'd0);
    end
    mem_read_ready = 1'b0;
    step();
    chk("stale_issue_valid", mem_read_valid, 32'd1);
    chk("stale_issue_addr", mem_read_address, 32'h99);
    rd_en = 1'b0; core_state = 3'd4; mem_read_ready = 1'b1; mem_read_data = 16'h4321;
    step();
    chk("ready_in_req_ignored", lsu_state, 32'd2);
    step();
    chk("stale_done", lsu_state, 32'd3);
    chk("stale_out", lsu_out, 32'h4321);
    mem_read_ready = 1'b0; core_state = 3'd6;
    step();
    core_state = 3'd0;

    // Reset in WAITING drops valid; a late ready is ignored afterwards.
    core_state = 3'd3; rd_en = 1'b1; rs = 16'h0011;
    step();
    rd_en = 1'b0; core_state = 3'd4;
    step();
    chk("rstw_waiting", lsu_state, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstw_valid", mem_read_valid, 32'd0);
    chk("rstw_state", lsu_state, 32'd0);
    mem_read_ready = 1'b1; mem_read_data = 16'hBAD0;
    step(); step();
    chk("late_ready_state", lsu_state, 32'd0);
    chk("late_ready_out", lsu_out, 32'd0);
    chk("late_ready_valid", mem_read_valid, 32'd0);
    mem_read_ready = 1'b0;

    // Disabled thread never issues.
    enable = 1'b0; core_state = 3'd3; rd_en = 1'b1; wr_en = 1'b1;
    step(); step();
    chk("disabled_state", lsu_state, 32'd0);
    chk("disabled_valid", mem_read_valid | mem_write_valid, 32'd0);
    core_state = 3'd0; rd_en = 1'b0; wr_en = 1'b0;

    // Randomized transactions against a transaction-level model.
    model_out = '0;
    model_err = 1'b0;
    for (int t = 0; t < 40; t++) begin
      int op, n, exp_done;
      logic rd_i, wr_i, is_rd;
      logic [DW-1:0] rs_i, rt_i, rdata;
      op = int'($urandom_range(0, 2));
      rd_i = (op != 1); wr_i = (op != 0);
      is_rd = rd_i;
      rs_i = DW'($urandom); rt_i = DW'($urandom); rdata = DW'($urandom);
      n = int'($urandom_range(0, 6));
      if (n + 1 <= TO) begin
        exp_done = n + 2;
        if (is_rd) model_out = rdata;
      end else begin
        exp_done = TO + 1;
        model_err = 1'b1;
      end
      run_txn(rd_i, wr_i, rs_i, rt_i, n, rdata, bit'($urandom_range(0, 1)),
              is_rd, rs_i[AW-1:0], rt_i, exp_done, model_out, model_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
